// File: rtl/memory_game_ctrl_pkg.sv
// Shared constants, state encoding and pair-id lookup for the card-matching game.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package memory_game_ctrl_pkg;

  localparam int NUM_CARDS = 16;
  localparam int GRID_DIM  = 4;
  localparam int PAIR_W    = 3;
  localparam int NUM_PAIRS = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PICK1 = 3'd1,
    ST_PICK2 = 3'd2,
    ST_SHOW  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Pair id stored for board position pos.
  function automatic logic [PAIR_W-1:0] pair_id(
    input logic [NUM_CARDS*PAIR_W-1:0] lay,
    input logic [3:0]                  pos
  );
    return lay[int'(pos)*PAIR_W +: PAIR_W];
  endfunction

endpackage

// File: rtl/memory_game_ctrl_cursor_nav.sv
// Cursor navigator: 4x4 grid position with per-axis wrap and up>down>left>right priority.
// Latency: 1 clk from button pulse to updated cursor.
// Backpressure: none; moves are dropped while en is low, clr always wins.
module memory_game_ctrl_cursor_nav (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [3:0] cursor
);

  logic [1:0] row;
  logic [1:0] col;

  assign cursor = {row, col};

  // Cursor register: 2-bit row/col arithmetic gives the wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= 2'd0;
      col <= 2'd0;
    end else if (clr) begin
      row <= 2'd0;
      col <= 2'd0;
    end else if (en) begin
      if (up)         row <= row - 2'd1;
      else if (down)  row <= row + 2'd1;
      else if (left)  col <= col - 2'd1;
      else if (right) col <= col + 2'd1;
    end
  end

endmodule

// File: rtl/memory_game_ctrl.sv
// Card-matching game sequencer: cursor, face-up/matched sets, reveal timer, score and attempts.
// Latency: every input pulse acts on the edge it is sampled; all outputs registered (1 clk).
// Backpressure: none; pulses arriving in states that cannot use them are dropped.
module memory_game_ctrl
  import memory_game_ctrl_pkg::*;
#(
  parameter int SHOW_CYCLES = 25_000_000,
  parameter int TIMER_W     = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        select,
  input  logic [47:0] layout,
  output logic [3:0]  cursor,
  output logic [15:0] card_show,
  output logic [15:0] matched,
  output logic [3:0]  pairs,
  output logic [7:0]  attempts,
  output logic        game_over
);

  state_t               state, state_n;
  logic [15:0]          face_up, face_up_n;
  logic [15:0]          matched_n;
  logic [3:0]           first, first_n;
  logic [3:0]           second, second_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [3:0]           pairs_n;
  logic [7:0]           attempts_n;
  logic [47:0]          layout_q, layout_n;
  logic                 sel_ok;
  logic                 cur_en;

  // Cursor moves only while a game is being played; start homes it.
  assign cur_en = (state == ST_PICK1) || (state == ST_PICK2) || (state == ST_SHOW);

  memory_game_ctrl_cursor_nav u_cursor_nav (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cur_en),
    .clr   (start),
    .up    (btn_up),
    .down  (btn_down),
    .left  (btn_left),
    .right (btn_right),
    .cursor(cursor)
  );

  // Next-state and next-value logic; select always uses the pre-move cursor.
  always_comb begin
    state_n    = state;
    face_up_n  = face_up;
    matched_n  = matched;
    first_n    = first;
    second_n   = second;
    timer_n    = timer;
    pairs_n    = pairs;
    attempts_n = attempts;
    layout_n   = layout_q;
    sel_ok     = select && !(face_up[cursor] || matched[cursor]);

    if (start) begin
      state_n    = ST_PICK1;
      face_up_n  = '0;
      matched_n  = '0;
      pairs_n    = '0;
      attempts_n = '0;
      timer_n    = '0;
      layout_n   = layout;
    end else begin
      case (state)
        ST_PICK1: begin
          if (sel_ok) begin
            face_up_n[cursor] = 1'b1;
            first_n           = cursor;
            state_n           = ST_PICK2;
          end
        end
        ST_PICK2: begin
          if (sel_ok) begin
            face_up_n[cursor] = 1'b1;
            second_n          = cursor;
            if (attempts != 8'hFF) attempts_n = attempts + 8'd1;
            timer_n           = TIMER_W'(SHOW_CYCLES - 1);
            state_n           = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (timer == '0) begin
            face_up_n[first]  = 1'b0;
            face_up_n[second] = 1'b0;
            if (pair_id(layout_q, first) == pair_id(layout_q, second)) begin
              matched_n[first]  = 1'b1;
              matched_n[second] = 1'b1;
              pairs_n           = pairs + 4'd1;
            end
            state_n = (pairs_n == 4'(NUM_PAIRS)) ? ST_DONE : ST_PICK1;
          end else begin
            timer_n = timer - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers; card_show/game_over are registered from next values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      face_up   <= '0;
      matched   <= '0;
      first     <= '0;
      second    <= '0;
      timer     <= '0;
      pairs     <= '0;
      attempts  <= '0;
      layout_q  <= '0;
      card_show <= '0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      face_up   <= face_up_n;
      matched   <= matched_n;
      first     <= first_n;
      second    <= second_n;
      timer     <= timer_n;
      pairs     <= pairs_n;
      attempts  <= attempts_n;
      layout_q  <= layout_n;
      card_show <= (state_n == ST_DONE) ? 16'hFFFF : (face_up_n | matched_n);
      game_over <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl with a short reveal time.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: n/a.
module tb_memory_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        select = 1'b0;
  logic [47:0] layout;
  logic [3:0]  cursor;
  logic [15:0] card_show;
  logic [15:0] matched;
  logic [3:0]  pairs;
  logic [7:0]  attempts;
  logic        game_over;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] cur = 4'd0;

  memory_game_ctrl #(.SHOW_CYCLES(4), .TIMER_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .select   (select),
    .layout   (layout),
    .cursor   (cursor),
    .card_show(card_show),
    .matched  (matched),
    .pairs    (pairs),
    .attempts (attempts),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic u, input logic d,
                       input logic l, input logic r, input logic sl);
    start = s; btn_up = u; btn_down = d; btn_left = l; btn_right = r; select = sl;
    tick();
    start = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; select = 0;
  endtask

  // dir: 0 up, 1 down, 2 left, 3 right; tracks expected cursor.
  task automatic mv(input int dir);
    logic [1:0] rr, cc;
    rr = cur[3:2];
    cc = cur[1:0];
    case (dir)
      0: begin pulse(0, 1, 0, 0, 0, 0); rr = rr - 2'd1; end
      1: begin pulse(0, 0, 1, 0, 0, 0); rr = rr + 2'd1; end
      2: begin pulse(0, 0, 0, 1, 0, 0); cc = cc - 2'd1; end
      default: begin pulse(0, 0, 0, 0, 1, 0); cc = cc + 2'd1; end
    endcase
    cur = {rr, cc};
  endtask

  task automatic sel();
    pulse(0, 0, 0, 0, 0, 1);
  endtask

  task automatic goto(input logic [3:0] t);
    while (cur[3:2] != t[3:2]) mv(1);
    while (cur[1:0] != t[1:0]) mv(3);
  endtask

  task automatic do_pair(input logic [3:0] a, input logic [3:0] b);
    goto(a);
    sel();
    goto(b);
    sel();
    repeat (4) tick();
  endtask

  initial begin
    for (int p = 0; p < 16; p++) layout[3*p +: 3] = 3'(p >> 1);

    // 1: reset state, reset mid-game, IDLE ignores buttons
    #2;
    check("rst_cursor", 32'(cursor), 0);
    check("rst_show", 32'(card_show), 0);
    check("rst_gameover", 32'(game_over), 0);
    rst_n = 1'b1;
    tick();
    pulse(1, 0, 0, 0, 0, 0);
    cur = 0;
    sel();
    check("pre_rst_show", 32'(card_show), 32'h0001);
    mv(3);
    rst_n = 1'b0;
    #1;
    check("midrst_cursor", 32'(cursor), 0);
    check("midrst_show", 32'(card_show), 0);
    check("midrst_attempts", 32'(attempts), 0);
    check("midrst_pairs", 32'({matched, pairs}), 0);
    #2;
    rst_n = 1'b1;
    pulse(0, 0, 0, 0, 1, 0);
    sel();
    cur = 0;
    check("idle_cursor", 32'(cursor), 0);
    check("idle_show", 32'(card_show), 0);

    // 2: matching pair (0,1)
    pulse(1, 0, 0, 0, 0, 0);
    sel();
    check("m_first_show", 32'(card_show), 32'h0001);
    check("m_first_att", 32'(attempts), 0);
    mv(3);
    sel();
    check("m_second_show", 32'(card_show), 32'h0003);
    check("m_second_att", 32'(attempts), 1);
    repeat (3) tick();
    check("m_show_hold", 32'(card_show), 32'h0003);
    check("m_show_nomatch_yet", 32'(matched), 0);
    tick();
    check("m_matched", 32'(matched), 32'h0003);
    check("m_pairs", 32'(pairs), 1);
    check("m_attempts", 32'(attempts), 1);

    // 3: mismatching pick (0,2) after a fresh start
    pulse(1, 0, 0, 0, 0, 0);
    cur = 0;
    sel();
    mv(3);
    mv(3);
    sel();
    check("x_show", 32'(card_show), 32'h0005);
    repeat (3) tick();
    check("x_show_hold", 32'(card_show), 32'h0005);
    tick();
    check("x_show_clear", 32'(card_show), 0);
    check("x_matched", 32'(matched), 0);
    check("x_attempts", 32'(attempts), 1);

    // 4: cursor wrap and move priority
    mv(3);
    check("cur_col3", 32'(cursor), 3);
    mv(3);
    check("cur_wrap_right", 32'(cursor), 0);
    mv(0);
    check("cur_wrap_up", 32'(cursor), 12);
    pulse(0, 1, 0, 1, 0, 0);
    cur = 4'd8;
    check("cur_up_left", 32'(cursor), 8);
    mv(2);
    check("cur_wrap_left", 32'(cursor), 11);

    // 5: ignored selects, select+move on same edge
    do_pair(0, 1);
    check("s_matched", 32'(matched), 32'h0003);
    check("s_attempts", 32'(attempts), 2);
    goto(0);
    sel();
    check("s_sel_matched_show", 32'(card_show), 32'h0003);
    check("s_sel_matched_att", 32'(attempts), 2);
    goto(2);
    sel();
    check("s_sel2_show", 32'(card_show), 32'h0007);
    sel();
    check("s_twice_show", 32'(card_show), 32'h0007);
    check("s_twice_att", 32'(attempts), 2);
    goto(4);
    sel();
    check("s_pick4_att", 32'(attempts), 3);
    mv(3);
    sel();
    check("s_show_sel", 32'(card_show), 32'h0017);
    check("s_show_cursor", 32'(cursor), 5);
    tick();
    tick();
    check("s_after_show", 32'(card_show), 32'h0003);
    check("s_after_att", 32'(attempts), 3);
    pulse(0, 0, 0, 0, 1, 1);
    cur = 4'd6;
    check("s_selmove_show", 32'(card_show), 32'h0023);
    check("s_selmove_cursor", 32'(cursor), 6);
    goto(4);
    sel();
    repeat (4) tick();
    check("s_pair45_matched", 32'(matched), 32'h0033);
    check("s_pair45_pairs", 32'(pairs), 2);

    // 6: finish the board, DONE behaviour, start from DONE and mid-SHOW
    do_pair(2, 3);
    do_pair(6, 7);
    do_pair(8, 9);
    do_pair(10, 11);
    do_pair(12, 13);
    goto(14);
    sel();
    goto(15);
    sel();
    repeat (3) tick();
    check("d_pre_gameover", 32'(game_over), 0);
    tick();
    check("d_pairs", 32'(pairs), 8);
    check("d_gameover", 32'(game_over), 1);
    check("d_show", 32'(card_show), 32'hFFFF);
    check("d_matched", 32'(matched), 32'hFFFF);
    check("d_attempts", 32'(attempts), 10);
    pulse(0, 0, 0, 0, 1, 1);
    check("d_cursor_frozen", 32'(cursor), 15);
    check("d_show_hold", 32'(card_show), 32'hFFFF);
    pulse(1, 0, 0, 0, 0, 0);
    cur = 0;
    check("r_show", 32'(card_show), 0);
    check("r_matched", 32'(matched), 0);
    check("r_counts", 32'({pairs, attempts}), 0);
    check("r_gameover", 32'(game_over), 0);
    check("r_cursor", 32'(cursor), 0);
    sel();
    mv(3);
    sel();
    tick();
    pulse(1, 0, 0, 0, 0, 0);
    cur = 0;
    check("ms_show", 32'(card_show), 0);
    check("ms_attempts", 32'(attempts), 0);
    check("ms_cursor", 32'(cursor), 0);
    repeat (5) tick();
    check("ms_show_later", 32'(card_show), 0);
    check("ms_matched_later", 32'(matched), 0);
    sel();
    check("ms_pick1", 32'(card_show), 32'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
